// File: rtl/sevenseg_pkg.sv
// Shared constants for the multiplexed seven-segment controller.
//   PWM_LEVELS : number of brightness phases per digit slot
//   SEG_OFF    : high-true segment pattern for a dark digit
//   GLYPHS     : high-true {g,f,e,d,c,b,a} patterns for hex 0..F
package sevenseg_pkg;

  localparam int PWM_LEVELS = 16;

  localparam logic [6:0] SEG_OFF = 7'b000_0000;

  // Standard hex glyphs; b and d are the lowercase forms.
  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/sevenseg_hex_decoder.sv
// Combinational hex-to-seven-segment lookup (high-true).
//   nibble : 4-bit hex value
//   seg    : segments {g,f,e,d,c,b,a}, 1 = lit
module sevenseg_hex_decoder
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = GLYPHS[nibble];

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller for NUM_DIGITS common-anode digits.
// Hex decode, per-digit dp and blanking, leading-zero suppression and 16-level
// PWM brightness. Input words are double-buffered and commit only at frame
// boundaries so a frame is never drawn from mixed data.
//   CLK100MHZ, reset   : clock, asynchronous active-high reset
//   load               : one-cycle strobe capturing digits_in/dp_in/blank_in/lz_en
//   digits_in          : nibble i drives digit i (digit 0 = rightmost)
//   dp_in, blank_in    : per-digit decimal point / force-dark requests
//   lz_en              : leading-zero suppression enable
//   brightness         : anode on for (brightness+1)/16 of each slot (live)
//   seg, dp, an        : display pins, polarity set by ACTIVE_LOW
//   frame_start        : one-cycle pulse when the scan wraps to digit 0
//
// Handshake: load is a strobe with no ready; every asserted cycle is accepted
// and the last load before a frame boundary is the one that gets displayed.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    CLK100MHZ,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  input  logic [3:0]              brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int TICK_DIV = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int SUB_DIV  = TICK_DIV / PWM_LEVELS;
  localparam int SUB_W    = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int DIG_W    = $clog2(NUM_DIGITS);

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);
  localparam bit               INV      = (ACTIVE_LOW != 0);

  generate
    if (TICK_DIV < 16 || (TICK_DIV % 16) != 0) begin : g_bad_div
      $error("sevenseg_scan_ctrl: TICK_DIV must be a nonzero multiple of 16");
    end
  endgenerate

  // Scan timing: sub_cnt -> phase -> digit_idx
  logic [SUB_W-1:0] sub_cnt;
  logic [3:0]       phase;
  logic [DIG_W-1:0] digit_idx;
  logic             sub_wrap;
  logic             boundary;

  assign sub_wrap = (sub_cnt == SUB_LAST);
  assign boundary = sub_wrap && (phase == 4'hF) && (digit_idx == DIG_LAST);

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      sub_cnt   <= '0;
      phase     <= '0;
      digit_idx <= '0;
    end else begin
      sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
      if (sub_wrap) begin
        phase <= phase + 4'd1;
        if (phase == 4'hF)
          digit_idx <= (digit_idx == DIG_LAST) ? '0 : digit_idx + 1'b1;
      end
    end
  end

  // Leading-zero suppression folded into the blank mask at commit time.
  // A force-blanked digit counts as zero so the scan continues through it.
  function automatic logic [NUM_DIGITS-1:0] lz_blank(
    input logic [4*NUM_DIGITS-1:0] d,
    input logic [NUM_DIGITS-1:0]   b,
    input logic                    en
  );
    logic                  scanning;
    logic [NUM_DIGITS-1:0] m;
    m        = b;
    scanning = en;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (scanning && (d[4*i +: 4] == 4'h0 || b[i]))
        m[i] = 1'b1;
      else
        scanning = 1'b0;
    end
    return m;
  endfunction

  // Shadow and active buffers
  logic [4*NUM_DIGITS-1:0] sh_digits, act_digits;
  logic [NUM_DIGITS-1:0]   sh_dp, act_dp;
  logic [NUM_DIGITS-1:0]   sh_blank, act_blank;
  logic                    sh_lz;
  logic                    pending;

  // A load coinciding with the boundary bypasses the shadow.
  logic [4*NUM_DIGITS-1:0] src_digits;
  logic [NUM_DIGITS-1:0]   src_dp;
  logic [NUM_DIGITS-1:0]   src_mask;

  always_comb begin
    src_digits = sh_digits;
    src_dp     = sh_dp;
    src_mask   = lz_blank(sh_digits, sh_blank, sh_lz);
    if (load) begin
      src_digits = digits_in;
      src_dp     = dp_in;
      src_mask   = lz_blank(digits_in, blank_in, lz_en);
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      sh_digits  <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      sh_lz      <= 1'b0;
      pending    <= 1'b0;
      act_digits <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
    end else begin
      if (load) begin
        sh_digits <= digits_in;
        sh_dp     <= dp_in;
        sh_blank  <= blank_in;
        sh_lz     <= lz_en;
      end
      if (boundary) begin
        pending <= 1'b0;
        if (load || pending) begin
          act_digits <= src_digits;
          act_dp     <= src_dp;
          act_blank  <= src_mask;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Output stage: decode current slot, register with polarity applied once.
  logic [3:0]            cur_nibble;
  logic [6:0]            glyph;
  logic [6:0]            seg_hi;
  logic [NUM_DIGITS-1:0] an_hi;
  logic                  dp_hi;
  logic                  lit;

  assign cur_nibble = act_digits[{digit_idx, 2'b00} +: 4];

  sevenseg_hex_decoder u_dec (
    .nibble (cur_nibble),
    .seg    (glyph)
  );

  always_comb begin
    lit    = (phase <= brightness) && !act_blank[digit_idx];
    an_hi  = '0;
    if (lit)
      an_hi[digit_idx] = 1'b1;
    seg_hi = act_blank[digit_idx] ? SEG_OFF : glyph;
    dp_hi  = act_dp[digit_idx];
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      seg         <= {7{INV}};
      dp          <= INV;
      an          <= {NUM_DIGITS{INV}};
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_hi ^ {7{INV}};
      dp          <= dp_hi ^ INV;
      an          <= an_hi ^ {NUM_DIGITS{INV}};
      frame_start <= boundary;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Self-checking bench for sevenseg_scan_ctrl (4 digits, 16 clocks per slot,
// one clock per PWM phase, active-low pins). The reference model works from
// the count of clock edges since reset: position = edges mod 64 gives the
// digit (position/16) and phase (position%16); pins lag by one edge.
module tb_sevenseg_scan_ctrl;

  localparam int ND    = 4;
  localparam int FRAME = 64;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            load;
  logic [4*ND-1:0] digits_in;
  logic [ND-1:0]   dp_in;
  logic [ND-1:0]   blank_in;
  logic            lz_en;
  logic [3:0]      brightness;
  logic [6:0]      seg;
  logic            dp;
  logic [ND-1:0]   an;
  logic            frame_start;

  sevenseg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .CLK_HZ     (1600),
    .REFRESH_HZ (25),
    .ACTIVE_LOW (1)
  ) dut (
    .CLK100MHZ   (clk),
    .reset       (reset),
    .load        (load),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .lz_en       (lz_en),
    .brightness  (brightness),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  // Active-low glyphs (segment low = lit), {g,f,e,d,c,b,a}
  logic [6:0] glyph_lo [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int errors = 0;
  int checks = 0;

  // Model state
  int              k;
  logic [4*ND-1:0] m_dig;
  logic [ND-1:0]   m_dp;
  logic [ND-1:0]   m_mask;
  logic [4*ND-1:0] s_dig;
  logic [ND-1:0]   s_dp;
  logic [ND-1:0]   s_blank;
  logic            s_lz;
  logic            m_pend;
  logic            seen_one;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (edge %0d)", tag, got, exp, k);
    end
  endtask

  // Digits shown dark: force-blanked ones plus leading zeros above digit 0.
  function automatic logic [ND-1:0] dark_mask(input logic [4*ND-1:0] d,
                                              input logic [ND-1:0] b,
                                              input logic lz);
    logic [ND-1:0] m;
    int top;
    m = b;
    if (lz) begin
      top = ND - 1;
      while (top > 0 && (d[4*top +: 4] == 4'h0 || b[top])) begin
        m[top] = 1'b1;
        top--;
      end
    end
    return m;
  endfunction

  task automatic model_reset();
    k      = 0;
    m_dig  = '0;
    m_dp   = '0;
    m_mask = '1;
    s_dig  = '0;
    s_dp   = '0;
    s_blank = '0;
    s_lz   = 1'b0;
    m_pend = 1'b0;
  endtask

  // One clock: predict pins from the pre-edge state, advance the model,
  // then compare after the edge.
  task automatic tick();
    int         pos, d, ph;
    logic [3:0] nib;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp, e_fs, bnd;
    pos   = k % FRAME;
    d     = pos / 16;
    ph    = pos % 16;
    nib   = m_dig[d*4 +: 4];
    e_an  = (ph <= int'(brightness) && !m_mask[d]) ? ~(4'b0001 << d) : 4'hF;
    e_seg = m_mask[d] ? 7'h7F : glyph_lo[nib];
    e_dp  = ~m_dp[d];
    bnd   = ((k + 1) % FRAME) == 0;
    e_fs  = bnd;
    if (bnd) begin
      if (load) begin
        m_dig  = digits_in;
        m_dp   = dp_in;
        m_mask = dark_mask(digits_in, blank_in, lz_en);
      end else if (m_pend) begin
        m_dig  = s_dig;
        m_dp   = s_dp;
        m_mask = dark_mask(s_dig, s_blank, s_lz);
      end
      m_pend = 1'b0;
    end else if (load) begin
      m_pend = 1'b1;
    end
    if (load) begin
      s_dig   = digits_in;
      s_dp    = dp_in;
      s_blank = blank_in;
      s_lz    = lz_en;
    end
    k++;
    @(posedge clk);
    #1;
    check("seg", 16'(seg), 16'(e_seg));
    check("an", 16'(an), 16'(e_an));
    check("dp", 16'(dp), 16'(e_dp));
    check("frame_start", 16'(frame_start), 16'(e_fs));
    if (an !== 4'hF && seg === glyph_lo[1]) seen_one = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_load(input logic [15:0] dg, input logic [3:0] dpv,
                         input logic [3:0] blk, input logic lz);
    digits_in = dg;
    dp_in     = dpv;
    blank_in  = blk;
    lz_en     = lz;
    load      = 1'b1;
    tick();
    load      = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    load       = 1'b0;
    digits_in  = '0;
    dp_in      = '0;
    blank_in   = '0;
    lz_en      = 1'b0;
    brightness = 4'hF;
    seen_one   = 1'b0;
    model_reset();

    // Reset values
    #1;
    check("rst_seg", 16'(seg), 16'h007F);
    check("rst_an", 16'(an), 16'h000F);
    check("rst_dp", 16'(dp), 16'h0001);
    check("rst_fs", 16'(frame_start), 16'h0000);
    #21;
    reset = 1'b0;

    // Dark until first commit, then 1234 at full brightness
    run(10);
    do_load(16'h1234, 4'h0, 4'h0, 1'b0);
    run(2 * FRAME);

    // Leading-zero suppression
    do_load(16'h00A5, 4'h0, 4'h0, 1'b1);
    run(2 * FRAME);
    do_load(16'h0000, 4'h0, 4'h0, 1'b1);
    run(2 * FRAME);

    // Brightness levels
    brightness = 4'd3;
    run(FRAME);
    brightness = 4'd0;
    run(FRAME);
    brightness = 4'hF;
    run(FRAME);

    // Two loads mid-frame: only the last one is ever shown
    while (k % FRAME != 20) tick();
    seen_one = 1'b0;
    do_load(16'h1111, 4'h0, 4'h0, 1'b0);
    tick();
    do_load(16'h2222, 4'h0, 4'h0, 1'b0);
    run(2 * FRAME);
    check("never_1111", 16'(seen_one), 16'h0000);

    // Load in the wrap cycle appears in slot 0 of the new frame
    while (k % FRAME != FRAME - 1) tick();
    do_load(16'h8C3E, 4'h0, 4'h0, 1'b0);
    tick();
    check("wrap_load_seg", 16'(seg), 16'(glyph_lo[14]));
    check("wrap_load_an", 16'(an), 16'h000E);
    run(FRAME);

    // Decimal point on digit 2, then reset mid-slot
    do_load(16'h5678, 4'b0100, 4'h0, 1'b0);
    run(2 * FRAME + 21);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_seg", 16'(seg), 16'h007F);
    check("mid_rst_an", 16'(an), 16'h000F);
    check("mid_rst_dp", 16'(dp), 16'h0001);
    check("mid_rst_fs", 16'(frame_start), 16'h0000);
    @(posedge clk);
    #1;
    check("hold_rst_an", 16'(an), 16'h000F);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run(2 * FRAME);
    do_load(16'h9ABC, 4'b0001, 4'h0, 1'b0);
    run(FRAME + 5);

    // Randomized loads, masks, suppression and brightness
    for (int it = 0; it < 30; it++) begin
      brightness = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) begin
        do_load(16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                1'($urandom_range(0, 1)));
        if ($urandom_range(0, 2) == 0) begin
          run($urandom_range(0, 4));
          do_load(16'($urandom_range(0, 255)), 4'($urandom), 4'h0, 1'b1);
        end
      end
      run($urandom_range(1, 90));
    end
    run(FRAME + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
